// File: rtl/census_frame_ctrl.sv
// census_frame_ctrl: frame sequencer feeding the census engine (clear, forward, pad, flush, status)
module census_frame_ctrl #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int CLR_CYCLES   = 2,
    parameter int FLUSH_PIXELS = 325
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_enable,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_sof,
    input  logic        s_eol,
    output logic        eng_rst,
    output logic        eng_valid,
    output logic [7:0]  eng_gray,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        err_short,
    output logic        err_long,
    output logic        err_sof,
    input  logic        err_clr
);
    localparam int CW = $clog2(IMAGE_WIDTH + 1);
    localparam int RW = $clog2(IMAGE_HEIGHT + 1);
    localparam int NW = $clog2((FLUSH_PIXELS > CLR_CYCLES ? FLUSH_PIXELS : CLR_CYCLES) + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam logic [NW-1:0] CLR_LAST = NW'(CLR_CYCLES - 1);
    localparam logic [NW-1:0] FL_LAST  = NW'(FLUSH_PIXELS - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, PAD, FLUSH} state_t;

    state_t        state, state_n;
    logic [CW-1:0] col, col_n;
    logic [RW-1:0] row, row_n;
    logic [NW-1:0] cnt, cnt_n;
    logic          fwd, inject, row_end, done_n;
    logic          set_short, set_long, set_sof;
    logic          mid_sof;

    // a sof away from col 0/row 0 is held back so it becomes the first pixel of the restarted frame
    assign mid_sof = s_valid & s_sof & ((col != '0) | (row != '0));
    assign s_ready = !rst & ((state == RUN & !mid_sof) |
                             (state == IDLE & (!(s_valid & s_sof) | !cfg_enable)));

    // next-state, counters and per-cycle events
    always_comb begin
        state_n   = state;
        col_n     = col;
        row_n     = row;
        cnt_n     = cnt;
        fwd       = 1'b0;
        inject    = 1'b0;
        row_end   = 1'b0;
        done_n    = 1'b0;
        set_short = 1'b0;
        set_long  = 1'b0;
        set_sof   = 1'b0;
        case (state)
            IDLE: if (s_valid & s_sof & cfg_enable) begin
                state_n = CLEAR;
                cnt_n   = '0;
            end
            CLEAR: if (cnt == CLR_LAST) begin
                state_n = RUN;
                col_n   = '0;
                row_n   = '0;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            RUN: if (mid_sof) begin
                set_sof = 1'b1;
                state_n = CLEAR;
                cnt_n   = '0;
            end else if (s_valid) begin
                fwd = 1'b1;
                if (col == COL_LAST) begin
                    set_long = !s_eol;
                    row_end  = 1'b1;
                end else begin
                    col_n = col + 1'b1;
                    if (s_eol) begin
                        set_short = 1'b1;
                        state_n   = PAD;
                    end
                end
            end
            PAD: begin
                inject = 1'b1;
                if (col == COL_LAST) row_end = 1'b1;
                else col_n = col + 1'b1;
            end
            FLUSH: begin
                inject = 1'b1;
                if (cnt == FL_LAST) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (row_end) begin
            col_n   = '0;
            row_n   = row + 1'b1;
            state_n = RUN;
            if (row == ROW_LAST) begin
                row_n   = '0;
                cnt_n   = '0;
                state_n = FLUSH;
            end
        end
    end

    // state, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            cnt        <= '0;
            eng_rst    <= 1'b1;
            eng_valid  <= 1'b0;
            eng_gray   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            err_sof    <= 1'b0;
        end else begin
            state      <= state_n;
            col        <= col_n;
            row        <= row_n;
            cnt        <= cnt_n;
            eng_rst    <= state_n == CLEAR;
            eng_valid  <= fwd | inject;
            eng_gray   <= fwd ? s_data : 8'd0;
            busy       <= state_n != IDLE;
            frame_done <= done_n;
            frame_cnt  <= frame_cnt + {15'd0, done_n};
            err_short  <= !err_clr & (err_short | set_short);
            err_long   <= !err_clr & (err_long | set_long);
            err_sof    <= !err_clr & (err_sof | set_sof);
        end
    end
endmodule

// File: tb/tb_census_frame_ctrl.sv
// tb_census_frame_ctrl: directed checks of the census frame sequencer on an 8x4 image
module tb_census_frame_ctrl;
    localparam int W = 8;
    localparam int H = 4;
    localparam int FL = 13;

    logic        clk = 0, rst = 1, cfg_enable = 0, s_valid = 0, s_sof = 0, s_eol = 0, err_clr = 0;
    logic [7:0]  s_data = 0;
    logic        s_ready, eng_rst, eng_valid, busy, frame_done, err_short, err_long, err_sof;
    logic [7:0]  eng_gray;
    logic [15:0] frame_cnt;

    census_frame_ctrl #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .CLR_CYCLES(2), .FLUSH_PIXELS(FL)) dut (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol), .eng_rst(eng_rst), .eng_valid(eng_valid),
        .eng_gray(eng_gray), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .err_short(err_short), .err_long(err_long), .err_sof(err_sof), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int compared = 0, mismatched = 0;
    logic [7:0] log_q[$];
    int rst_cyc = 0, done_cnt = 0;

    // record engine strobes, clear pulses and frame completions mid-cycle
    always @(negedge clk) begin
        if (eng_valid) log_q.push_back(eng_gray);
        if (eng_rst && !rst) rst_cyc++;
        if (frame_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] d, input logic sof, input logic eol);
        int n = 0;
        logic ok = 0;
        s_valid = 1; s_data = d; s_sof = sof; s_eol = eol;
        do begin
            @(negedge clk); ok = s_ready;
            @(posedge clk); #1; n++;
        end while (!ok && n < 100);
        s_valid = 0; s_sof = 0; s_eol = 0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic send_row(input int v, input int n, input logic sof, input logic eol);
        for (int i = 0; i < n; i++) send(8'(v + i), sof && i == 0, eol && i == n - 1);
    endtask

    task automatic wait_done(input int base);
        int n = 0;
        while (done_cnt == base && n < 300) begin @(posedge clk); #1; n++; end
        chk("done_timeout", done_cnt != base, 1);
    endtask

    int b, br, bd, bad;

    initial begin
        cyc(2);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_eng_rst", eng_rst, 1);
        chk("rst_eng_valid", eng_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_errs", {err_short, err_long, err_sof}, 0);
        rst = 0; cfg_enable = 1;
        cyc(2);

        // clean frame
        b = log_q.size(); br = rst_cyc; bd = done_cnt;
        for (int r = 0; r < H; r++) send_row(1 + W * r, W, r == 0, 1);
        wait_done(bd); cyc(2);
        chk("t1_strobes", log_q.size() - b, W * H + FL);
        chk("t1_clr_cycles", rst_cyc - br, 2);
        bad = 0;
        for (int i = 0; i < W * H + FL; i++) if (log_q[b + i] !== ((i < 32) ? 8'(i + 1) : 8'd0)) bad++;
        chk("t1_data", bad, 0);
        chk("t1_done", done_cnt - bd, 1);
        chk("t1_frame_cnt", frame_cnt, 1);
        chk("t1_errs", {err_short, err_long, err_sof}, 0);
        chk("t1_busy", busy, 0);

        // short row 1
        b = log_q.size(); bd = done_cnt;
        send_row(1, 8, 1, 1); send_row(9, 5, 0, 1); send_row(14, 8, 0, 1); send_row(22, 8, 0, 1);
        wait_done(bd); cyc(2);
        chk("t2_strobes", log_q.size() - b, 45);
        chk("t2_last", log_q[b + 12], 13);
        chk("t2_pad", {log_q[b + 13], log_q[b + 14], log_q[b + 15]}, 0);
        chk("t2_row2", log_q[b + 16], 14);
        chk("t2_row3", log_q[b + 24], 22);
        chk("t2_err_short", err_short, 1);
        chk("t2_err_long", err_long, 0);
        chk("t2_frame_cnt", frame_cnt, 2);
        err_clr = 1; cyc(1); err_clr = 0;
        chk("t2_clr", err_short, 0);

        // long row 0
        b = log_q.size(); bd = done_cnt;
        send_row(1, 10, 1, 1); send_row(11, 8, 0, 1); send_row(19, 8, 0, 1);
        wait_done(bd); cyc(2);
        chk("t3_strobes", log_q.size() - b, 45);
        chk("t3_r0c7", log_q[b + 7], 8);
        chk("t3_r1c0", log_q[b + 8], 9);
        chk("t3_r1c1", log_q[b + 9], 10);
        chk("t3_pad", log_q[b + 10], 0);
        chk("t3_row2", log_q[b + 16], 11);
        chk("t3_err_long", err_long, 1);
        chk("t3_err_short", err_short, 1);
        chk("t3_frame_cnt", frame_cnt, 3);
        err_clr = 1; cyc(1); err_clr = 0;

        // sof at row 2 col 3
        b = log_q.size(); br = rst_cyc; bd = done_cnt;
        send_row(1, 8, 1, 1); send_row(9, 8, 0, 1); send_row(17, 3, 0, 0);
        send(99, 1, 0); send_row(100, 7, 0, 1);
        send_row(107, 8, 0, 1); send_row(115, 8, 0, 1); send_row(123, 8, 0, 1);
        wait_done(bd); cyc(2);
        chk("t4_strobes", log_q.size() - b, 64);
        chk("t4_before", log_q[b + 18], 19);
        chk("t4_restart", log_q[b + 19], 99);
        chk("t4_next", log_q[b + 20], 100);
        chk("t4_clr_cycles", rst_cyc - br, 4);
        chk("t4_done", done_cnt - bd, 1);
        chk("t4_frame_cnt", frame_cnt, 4);
        chk("t4_err_sof", err_sof, 1);
        err_clr = 1; cyc(1); err_clr = 0;

        // idle discards and disabled start
        b = log_q.size(); br = rst_cyc;
        send(5, 0, 0); send(6, 0, 0); send(7, 0, 0);
        cyc(2);
        chk("t5_discard", log_q.size() - b, 0);
        chk("t5_busy", busy, 0);
        cfg_enable = 0; s_valid = 1; s_sof = 1;
        cyc(1);
        chk("t5_ready_dis", s_ready, 1);
        cyc(4);
        chk("t5_busy_dis", busy, 0);
        chk("t5_no_clr", rst_cyc - br, 0);
        s_valid = 0; s_sof = 0; cfg_enable = 1;
        cyc(1);

        // gapped input, then reset mid-run
        b = log_q.size();
        for (int i = 0; i < 6; i++) begin
            send(8'(40 + i), i == 0, 0);
            if (i < 5) cyc($urandom_range(0, 3));
        end
        chk("t6_valid", eng_valid, 1);
        chk("t6_gray", eng_gray, 45);
        cyc(1);
        chk("t6_gap", eng_valid, 0);
        chk("t6_strobes", log_q.size() - b, 6);
        bad = 0;
        for (int i = 0; i < 6; i++) if (log_q[b + i] !== 8'(40 + i)) bad++;
        chk("t6_data", bad, 0);
        rst = 1; cyc(1);
        chk("t6_rst_valid", eng_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_eng_rst", eng_rst, 1);
        chk("t6_rst_ready", s_ready, 0);
        chk("t6_rst_frame_cnt", frame_cnt, 0);
        rst = 0; cyc(2);

        // err_clr wins over a simultaneous short-row event
        send_row(1, 3, 1, 0);
        err_clr = 1; send(4, 0, 1); err_clr = 0;
        chk("t7_clr_priority", err_short, 0);
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
